// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq -- iterative radix-2 restoring divider for the MIPS EX stage
// (DIV / DIVU).
//
// When EX issues a divide, the operands are latched. Thirty-two restoring
// steps then run, one per clock, while busy stalls the pipeline. In the
// following cycle the quotient (LO) and remainder (HI) are valid, and done
// pulses for one cycle. An exception flush (cancel) aborts the divide at
// any point, and a cancelled divide never produces a done pulse.
//
// Ports:
//   clk         core clock, rising edge
//   resetn      asynchronous active-low reset
//   start       EX holds a DIV/DIVU (level, held while stalled)
//   signed_div  1 = DIV (two's complement), 0 = DIVU
//   dividend    rs value, sampled with start
//   divisor     rt value, sampled with start
//   cancel      exception/ERET flush of EX, has priority over start
//   busy        stall request (combinational, high in the issue cycle)
//   done        one-cycle pulse: quotient/remainder valid, HI/LO write
//   quotient    to LO, holds the last completed result
//   remainder   to HI, holds the last completed result
//
// Build option:
//   DIV_ZERO_FAST_EN  when defined, a zero divisor skips the iterations and
//                     finishes in the cycle after issue. The result values
//                     are identical either way.
// ---------------------------------------------------------------------------
module div_seq (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int DATA_W = 32;

`ifdef DIV_ZERO_FAST_EN
  localparam logic FAST_ZERO = 1'b1;
`else
  localparam logic FAST_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [4:0]        cnt;

  // Working datapath registers (not reset; always loaded at issue).
  logic [DATA_W-1:0] rem_acc;
  logic [DATA_W-1:0] quo_acc;
  logic [DATA_W-1:0] div_mag;
  logic [DATA_W-1:0] dvd_raw;
  logic              neg_q;
  logic              neg_r;
  logic              dz;

  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] q_fin;
  logic [DATA_W-1:0] r_fin;
  logic              issue;

  // Magnitude of an operand. The most negative value maps to 32'h80000000,
  // which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                            input logic sgn_mode);
    if (sgn_mode && (v < 0))
      return -v;
    else
      return v;
  endfunction

  // Sign fixup: two's-complement negate when neg is set. Negating
  // 32'h80000000 yields 32'h80000000, which gives the overflow result.
  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] m,
                                                   input logic neg);
    logic signed [DATA_W-1:0] s;
    s = signed'(m);
    if (neg)
      return -s;
    else
      return s;
  endfunction

  assign issue = (state == IDLE) && start && !cancel;
  assign busy  = issue || ((state == RUN) && !cancel);

  // One restoring step: shift remainder:quotient left, then trial-subtract.
  always_comb begin
    shifted = {rem_acc, quo_acc[DATA_W-1]};
    trial   = shifted - {1'b0, div_mag};
    rem_nxt = shifted[DATA_W-1:0];
    quo_nxt = {quo_acc[DATA_W-2:0], 1'b0};
    if (!trial[DATA_W]) begin
      rem_nxt = trial[DATA_W-1:0];
      quo_nxt = {quo_acc[DATA_W-2:0], 1'b1};
    end
  end

  // A zero divisor forces the architectural result over any fixup.
  assign q_fin = dz ? {DATA_W{1'b1}} : apply_sign(quo_nxt, neg_q);
  assign r_fin = dz ? dvd_raw        : apply_sign(rem_nxt, neg_r);

  // Issue stage: latch magnitudes, signs and raw dividend.
  always_ff @(posedge clk) begin
    if (issue) begin
      rem_acc <= '0;
      quo_acc <= mag(dividend, signed_div);
      div_mag <= mag(divisor, signed_div);
      dvd_raw <= dividend;
      neg_q   <= signed_div & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      neg_r   <= signed_div & dividend[DATA_W-1];
      dz      <= (divisor == '0);
    end else if (state == RUN) begin
      rem_acc <= rem_nxt;
      quo_acc <= quo_nxt;
    end
  end

  // Control and result registers. The results are loaded on the edge that
  // enters DONE, so they are valid while done is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (start) begin
              if (FAST_ZERO && (divisor == '0)) begin
                state     <= DONE;
                done      <= 1'b1;
                quotient  <= {DATA_W{1'b1}};
                remainder <= dividend;
              end else begin
                state <= RUN;
              end
            end
          end
          RUN: begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= q_fin;
              remainder <= r_fin;
            end
          end
          DONE: begin
            // start is still the same instruction advancing; ignore it.
            state <= IDLE;
            cnt   <= '0;
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq -- directed bench for div_seq. A behavioural model that uses
// plain integer division and a done-cycle schedule is checked against the
// DUT every cycle. Each directed vector also carries hand-computed results
// and latency.
// ---------------------------------------------------------------------------
module tb_div_seq;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  // model state
  bit          m_active = 1'b0;
  int          m_done_at = 0;
  logic [31:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

  div_seq dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .signed_div(signed_div),
    .dividend  (dividend),
    .divisor   (divisor),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Architectural result of DIV/DIVU from plain arithmetic.
  task automatic model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Model: schedules the done cycle at issue and updates outputs on entry.
  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_active = 1'b0;
        m_q = '0;
        m_r = '0;
      end else begin
        if (cancel) begin
          m_active = 1'b0;
        end else if (m_active) begin
          if (cyc == m_done_at) m_active = 1'b0;
        end else if (start) begin
          m_active  = 1'b1;
          m_done_at = cyc + ((divisor == 0) ? ZLAT : 33);
          model_div(signed_div, dividend, divisor, p_q, p_r);
        end
        cyc = cyc + 1;
        if (m_active && (cyc == m_done_at)) begin
          m_q = p_q;
          m_r = p_r;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    logic exp_busy, exp_done;
    forever begin
      @(negedge clk);
      exp_done = m_active && (cyc == m_done_at);
      exp_busy = (!m_active && start && !cancel) ||
                 (m_active && (cyc < m_done_at) && !cancel);
      if (done === 1'b1) done_cnt++;
      chk("cyc_busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("cyc_done", {31'd0, done}, {31'd0, exp_done});
      chk("cyc_quotient", quotient, m_q);
      chk("cyc_remainder", remainder, m_r);
    end
  end

  // Issue one divide at the current time (shortly after a rising edge),
  // wait for done, check literal results and latency. hold keeps start high
  // afterwards so the next call issues back-to-back.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input int lat, input bit hold);
    int c0;
    bit seen;
    signed_div = sgn;
    dividend   = a;
    divisor    = b;
    start      = 1'b1;
    c0         = cyc;
    #1;
    chk({name, "_busy_issue"}, {31'd0, busy}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done within 40 cycles", name);
    end else begin
      chk({name, "_latency"}, 32'(cyc - c0), 32'(lat));
      chk({name, "_q"}, quotient, eq);
      chk({name, "_r"}, remainder, er);
    end
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    #2;
    chk({name, "_single_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dc;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33, 1'b1);
    run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33, 1'b0);
    run_div("divu_zero", 1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, ZLAT, 1'b0);
    run_div("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 33, 1'b0);
    run_div("divu_big", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33, 1'b0);
    run_div("div_min_2", 1'b1, 32'h80000000, 32'd2, 32'hC0000000, 32'd0, 33, 1'b0);
    run_div("divu_ff_16", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 33, 1'b0);
    run_div("div_zero", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, ZLAT, 1'b0);

    // Cancel at iteration 10 of DIVU 50/5, then DIVU 9/4 in the next cycle.
    @(posedge clk);
    #1;
    dc         = done_cnt;
    signed_div = 1'b0;
    dividend   = 32'd50;
    divisor    = 32'd5;
    start      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("cancel_no_done", 32'(done_cnt), 32'(dc));
    chk("cancel_hold_q", quotient, 32'hFFFFFFFF);
    chk("cancel_hold_r", remainder, 32'hFFFFFFFB);
    run_div("divu_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33, 1'b0);

    // Asynchronous reset in the middle of RUN.
    @(posedge clk);
    #1;
    signed_div = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    start      = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    dc     = done_cnt;
    resetn = 1'b0;
    #1;
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(posedge clk);
    chk("arst_no_done", 32'(done_cnt), 32'(dc));
    #1;
    run_div("divu_after_rst", 1'b0, 32'hFFFFFFFF, 32'd3, 32'h55555555, 32'd0, 33, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
